// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_pkg
//  Description : Shared types and constants for the serial receive collector.
//                RX_PARITY_EN selects 9 bits per byte (8 data + even parity).
//  Revision    : 1.0  initial release
// ============================================================================
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  localparam int BYTE_W = 8;

`ifdef RX_PARITY_EN
  localparam int BITS_PER_BYTE = 9;
`else
  localparam int BITS_PER_BYTE = 8;
`endif

  // Bit counter must reach BITS_PER_BYTE-1 (7 or 8)
  localparam int BIT_CNT_W = (BITS_PER_BYTE > 8) ? 4 : 3;

endpackage
`default_nettype wire

// File: rtl/serial_rx_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_collector_if
//  Description : Ready/valid SRAM write port between the collector (master)
//                and the memory controller (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_rx_collector_if #(
  parameter int ADDR_W = 4
);
  import serial_rx_pkg::*;

  logic [ADDR_W-1:0] memAddr;
  logic [BYTE_W-1:0] memData;
  logic              memWrite;
  logic              memReady;

  modport master (output memAddr, output memData, output memWrite, input memReady);
  modport slave  (input memAddr, input memData, input memWrite, output memReady);

endinterface
`default_nettype wire

// File: rtl/serial_rx_collector_sync.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sync
//  Description : Equal-depth synchronizers for the remote bit clock and data
//                line, plus rising-edge detection on the clock path. The data
//                output is aligned with the edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_clk,
  input  logic serial_in,
  output logic bit_edge,
  output logic bit_data
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_dly_q, clk_dly_d;

  // Shift both lines one stage deeper per clk; extra delay flop on clock only
  always_comb begin
    clk_sync_d     = clk_sync_q;
    data_sync_d    = data_sync_q;
    clk_sync_d[0]  = serial_clk;
    data_sync_d[0] = serial_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      clk_sync_d[i]  = clk_sync_q[i-1];
      data_sync_d[i] = data_sync_q[i-1];
    end
    clk_dly_d = clk_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer registers, cleared by the active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_dly_q   <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_dly_q   <= clk_dly_d;
    end
  end

  assign bit_edge = clk_sync_q[SYNC_STAGES-1] & ~clk_dly_q;
  assign bit_data = data_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/serial_rx_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_rx_collector
//  Description : Recovers LSB-first bytes from an asynchronous serial link and
//                writes a NUM_BYTES frame to SRAM through a ready/valid port,
//                buffering completed bytes in a 2-entry FIFO.
//                Optional macro RX_PARITY_EN: 9th even-parity bit per byte.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_rx_collector
  import serial_rx_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int NUM_BYTES   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxEn,
  input  logic                  serialClk,
  input  logic                  serialIn,
  serial_rx_collector_if.master mem,
  output logic                  rxDone,
  output logic                  overrun,
  output logic                  parityErr
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  rx_state_e            state_q, state_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    fifo_q [2];
  logic [BYTE_W-1:0]    fifo_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_err_q, parity_err_d;

  logic                 bit_edge, bit_data;
  logic                 rx_edge, last_bit, push_req, push, pop, mem_write;
  logic [BYTE_W-1:0]    new_byte;
  logic                 bad_parity;

  serial_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .serial_clk (serialClk),
    .serial_in  (serialIn),
    .bit_edge   (bit_edge),
    .bit_data   (bit_data)
  );

  assign mem_write = (state_q == RECV) && (cnt_q != 2'd0);
  assign pop       = mem_write && mem.memReady;
  assign rx_edge   = bit_edge && (state_q == RECV);
  assign last_bit  = (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1));
  assign push_req  = rx_edge && last_bit;
  // A pop on the same cycle frees a slot, so a full FIFO still takes the byte
  assign push      = push_req && ((cnt_q != 2'd2) || pop);

`ifdef RX_PARITY_EN
  // Data bits are already in the shifter; the 9th bit is parity only
  assign new_byte   = shift_q;
  assign bad_parity = ^{shift_q, bit_data};
`else
  assign new_byte   = {bit_data, shift_q[BYTE_W-1:1]};
  assign bad_parity = 1'b0;
`endif

  // Next-state for FSM, shifter, FIFO, address and sticky flags
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    overrun_d    = overrun_q;
    parity_err_d = parity_err_q;

    case (state_q)
      IDLE:    if (rxEn) state_d = RECV;
      RECV:    if (pop && (byte_cnt_q == CNT_W'(NUM_BYTES - 1))) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (rx_edge) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BIT_CNT_W'(1);
      if ((BITS_PER_BYTE == BYTE_W) || !last_bit) begin
        shift_d = {bit_data, shift_q[BYTE_W-1:1]};
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = new_byte;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (push_req && !push) overrun_d = 1'b1;
    if (push && bad_parity) parity_err_d = 1'b1;

    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      addr_d     = addr_q + ADDR_W'(1);
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Disable flushes everything except the sticky error flags
    if (!rxEn) begin
      state_d    = IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
      addr_d     = '0;
      byte_cnt_d = '0;
    end
  end

  // State registers with active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      byte_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      for (int i = 0; i < 2; i++) fifo_q[i] <= fifo_d[i];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      byte_cnt_q   <= byte_cnt_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign mem.memAddr  = addr_q;
  assign mem.memData  = fifo_q[rd_ptr_q];
  assign mem.memWrite = mem_write;
  assign rxDone       = (state_q == DONE);
  assign overrun      = overrun_q;
  assign parityErr    = parity_err_q;

endmodule
`default_nettype wire
